motor_pwm_driver: RTL and testbench

- Receives the run/speed commands produced by the operator-interface block and turns them into the actual motor PWM waveform.
- Holds a duty level of 0..9. On start it soft-ramps the level to a default, then accepts single-step increase/decrease commands.
- Drives a 7-segment digit showing the current level.
- Sits between the operator interface and the motor power stage and display.

---
 rtl/motor_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 29 ++
 rtl/motor_pwm_driver.sv | 166 ++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the motor PWM driver slice.
//   - state_t    : controller state encoding (IDLE / RAMP / RUN)
//   - LEVEL_W    : width of the duty level bus
//   - SLOTS      : PWM slots per period
//   - SEG_*      : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
package motor_pkg;

  localparam int LEVEL_W = 4;
  localparam int SEG_W   = 7;
  localparam int SLOTS   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: purely combinational 4-bit value to active-low 7-segment code.
// Ports:
//   value : digit to show (0..9 meaningful)
//   seg   : active-low segments {g,f,e,d,c,b,a}; "-" for any value above 9
module seg7_decoder
  import motor_pkg::*;
(
  input  logic [LEVEL_W-1:0] value,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: turns run / step commands into a 10-slot PWM waveform,
// soft-ramping the duty level to a default on start, and shows the level
// on a 7-segment digit.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   motor_running  : run command level (1 = run, 0 = stop)
//   inc_req        : increase switch level (stepped on rising edge only)
//   dec_req        : decrease switch level (stepped on rising edge only)
//   pwm_out        : registered PWM to the power stage
//   duty_level     : registered current duty level 0..MAX_LEVEL
//   display        : registered active-low segment code of duty_level
//   active         : registered, 1 while ramping or running
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int STEP_CLKS     = 1000,
  parameter int DEFAULT_LEVEL = 5,
  parameter int MAX_LEVEL     = 9,
  parameter int RAMP_PERIODS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               motor_running,
  input  logic               inc_req,
  input  logic               dec_req,
  output logic               pwm_out,
  output logic [LEVEL_W-1:0] duty_level,
  output logic [SEG_W-1:0]   display,
  output logic               active
);

  localparam int PRESC_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int SLOT_W  = $clog2(SLOTS);
  localparam int RAMP_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST    = PRESC_W'(STEP_CLKS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST     = SLOT_W'(SLOTS - 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST     = RAMP_W'(RAMP_PERIODS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_DEFAULT = LEVEL_W'(DEFAULT_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX     = LEVEL_W'(MAX_LEVEL);

  state_t               state_reg, state_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [SLOT_W-1:0]    slot_reg, slot_next;
  logic [RAMP_W-1:0]    ramp_reg, ramp_next;
  logic [LEVEL_W-1:0]   level_reg, level_next;
  logic                 inc_prev_reg, dec_prev_reg;
  logic                 pwm_reg, pwm_next;
  logic                 active_reg, active_next;
  logic [SEG_W-1:0]     display_reg, seg_code;

  // Step pulses from sampled 0->1 transitions; simultaneous pulses cancel.
  logic inc_pulse, dec_pulse, step_up, step_down;
  assign inc_pulse = inc_req & ~inc_prev_reg;
  assign dec_pulse = dec_req & ~dec_prev_reg;
  assign step_up   = inc_pulse & ~dec_pulse;
  assign step_down = dec_pulse & ~inc_pulse;

  // Timebase events.
  logic presc_wrap, period_end, ramp_step, ramp_done;
  assign presc_wrap = (presc_reg == PRESC_LAST);
  assign period_end = presc_wrap && (slot_reg == SLOT_LAST);
  assign ramp_step  = period_end && (ramp_reg == RAMP_LAST);
  // The ramp finishes in the same cycle the level lands on the default.
  assign ramp_done  = ramp_step && ((level_reg + LEVEL_W'(1)) == LEVEL_DEFAULT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a stop command wins from any state.
  always_comb begin
    state_next = state_reg;
    if (!motor_running) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = RAMP;
        RAMP:    if (ramp_done) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters and level datapath.
  always_comb begin
    presc_next = presc_reg;
    slot_next  = slot_reg;
    ramp_next  = ramp_reg;
    level_next = level_reg;

    // Counters are held at zero around IDLE so each run starts at slot 0.
    if (state_reg == IDLE || state_next == IDLE) begin
      presc_next = PRESC_W'(0);
      slot_next  = SLOT_W'(0);
    end else if (presc_wrap) begin
      presc_next = PRESC_W'(0);
      slot_next  = (slot_reg == SLOT_LAST) ? SLOT_W'(0) : slot_reg + SLOT_W'(1);
    end else begin
      presc_next = presc_reg + PRESC_W'(1);
    end

    if (state_next == IDLE || state_reg == IDLE) begin
      level_next = LEVEL_W'(0);
      ramp_next  = RAMP_W'(0);
    end else if (state_reg == RAMP) begin
      if (period_end) begin
        if (ramp_step) begin
          ramp_next  = RAMP_W'(0);
          level_next = level_reg + LEVEL_W'(1);
        end else begin
          ramp_next = ramp_reg + RAMP_W'(1);
        end
      end
    end else begin
      if (step_up && level_reg < LEVEL_MAX)
        level_next = level_reg + LEVEL_W'(1);
      else if (step_down && level_reg != LEVEL_W'(0))
        level_next = level_reg - LEVEL_W'(1);
    end
  end

  // Outputs are derived from next values so they line up with the level register.
  always_comb begin
    active_next = (state_next != IDLE);
    pwm_next    = (state_next != IDLE) && (32'(slot_next) < 32'(level_next));
  end

  seg7_decoder u_seg7 (
    .value (level_next),
    .seg   (seg_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg    <= PRESC_W'(0);
      slot_reg     <= SLOT_W'(0);
      ramp_reg     <= RAMP_W'(0);
      level_reg    <= LEVEL_W'(0);
      inc_prev_reg <= 1'b0;
      dec_prev_reg <= 1'b0;
      pwm_reg      <= 1'b0;
      active_reg   <= 1'b0;
      display_reg  <= SEG_0;
    end else begin
      presc_reg    <= presc_next;
      slot_reg     <= slot_next;
      ramp_reg     <= ramp_next;
      level_reg    <= level_next;
      inc_prev_reg <= inc_req;
      dec_prev_reg <= dec_req;
      pwm_reg      <= pwm_next;
      active_reg   <= active_next;
      display_reg  <= seg_code;
    end
  end

  assign pwm_out    = pwm_reg;
  assign duty_level = level_reg;
  assign display    = display_reg;
  assign active     = active_reg;

endmodule

// File: tb/tb_motor_pwm_driver.sv
module tb_motor_pwm_driver;

  localparam int S    = 2;
  localparam int RP   = 1;
  localparam int DEF  = 5;
  localparam int MAXL = 9;
  localparam int PER  = 10 * S;

  logic       clk = 1'b0;
  logic       rst, motor_running, inc_req, dec_req;
  logic       pwm_out, active;
  logic [3:0] duty_level;
  logic [6:0] display;

  motor_pwm_driver #(
    .STEP_CLKS     (S),
    .DEFAULT_LEVEL (DEF),
    .MAX_LEVEL     (MAXL),
    .RAMP_PERIODS  (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .motor_running (motor_running),
    .inc_req       (inc_req),
    .dec_req       (dec_req),
    .pwm_out       (pwm_out),
    .duty_level    (duty_level),
    .display       (display),
    .active        (active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Reference model: mode 0 stopped, 1 ramping, 2 running.
  // m_k = clocks elapsed since the run started; slot and ramp level follow by division.
  int m_mode  = 0;
  int m_level = 0;
  int m_k     = 0;
  bit m_prev_inc = 1'b0;
  bit m_prev_dec = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ip, dp;
    ip = inc_req && !m_prev_inc;
    dp = dec_req && !m_prev_dec;
    m_prev_inc = inc_req;
    m_prev_dec = dec_req;
    if (rst) begin
      m_mode = 0; m_level = 0; m_k = 0; m_prev_inc = 0; m_prev_dec = 0;
    end else if (!motor_running) begin
      m_mode = 0; m_level = 0; m_k = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_level = 0; m_k = 0;
    end else begin
      m_k++;
      if (m_mode == 1) begin
        m_level = m_k / (PER * RP);
        if (m_level >= DEF) begin
          m_level = DEF;
          m_mode  = 2;
        end
      end else begin
        if (ip && !dp && m_level < MAXL) m_level++;
        else if (dp && !ip && m_level > 0) m_level--;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_pwm;
    exp_pwm = (m_mode != 0) && (((m_k % PER) / S) < m_level);
    check("pwm",     8'(pwm_out),    8'(exp_pwm));
    check("level",   8'(duty_level), 8'(m_level));
    check("active",  8'(active),     8'(m_mode != 0));
    check("display", 8'(display),    8'(seg_tbl[m_level]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_level(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (duty_level === 4'(target)) break;
      tick();
    end
    check("wait_level", 8'(duty_level), 8'(target));
  endtask

  task automatic pulse_inc();
    inc_req = 1'b1; tick();
    inc_req = 1'b0; tick();
  endtask

  task automatic pulse_dec();
    dec_req = 1'b1; tick();
    dec_req = 1'b0; tick();
  endtask

  int highs;

  initial begin
    rst = 1'b1; motor_running = 1'b1; inc_req = 1'b0; dec_req = 1'b0;

    $display("step: reset held 3 cycles with run=1");
    repeat (3) tick();
    check("rst_pwm",     8'(pwm_out),    8'd0);
    check("rst_level",   8'(duty_level), 8'd0);
    check("rst_display", 8'(display),    8'h40);
    check("rst_active",  8'(active),     8'd0);

    $display("step: release reset, ramp to default");
    rst = 1'b0;
    tick();
    check("ramp_entry_active", 8'(active), 8'd1);
    wait_level(DEF, 6 * PER);
    check("run_display5", 8'(display), 8'h12);

    $display("step: measure duty at level 5 over two periods");
    highs = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    check("duty5_highs", 8'(highs), 8'd20);

    $display("step: increase to 9 and saturate");
    repeat (4) pulse_inc();
    check("level9", 8'(duty_level), 8'd9);
    repeat (3) pulse_inc();
    check("sat9_level",   8'(duty_level), 8'd9);
    check("sat9_display", 8'(display),    8'h10);
    highs = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    check("duty9_highs", 8'(highs), 8'd18);

    $display("step: ten decreases to 0");
    repeat (10) pulse_dec();
    check("sat0_level", 8'(duty_level), 8'd0);
    highs = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    check("duty0_highs",  8'(highs),  8'd0);
    check("sat0_active",  8'(active), 8'd1);

    $display("step: back to 5, simultaneous inc/dec");
    repeat (5) pulse_inc();
    inc_req = 1'b1; dec_req = 1'b1; tick();
    inc_req = 1'b0; dec_req = 1'b0; tick();
    check("both_level", 8'(duty_level), 8'd5);

    $display("step: inc held for 100 cycles");
    inc_req = 1'b1;
    repeat (100) tick();
    inc_req = 1'b0;
    tick();
    check("held_level", 8'(duty_level), 8'd6);

    $display("step: stop, restart, stop again at ramp level 2");
    motor_running = 1'b0; tick();
    check("stop_active", 8'(active), 8'd0);
    motor_running = 1'b1; tick();
    wait_level(2, 4 * PER);
    motor_running = 1'b0; tick();
    check("abort_level",  8'(duty_level), 8'd0);
    check("abort_active", 8'(active),     8'd0);
    check("abort_pwm",    8'(pwm_out),    8'd0);

    $display("step: restart with random switch activity during ramp");
    motor_running = 1'b1; tick();
    check("restart_level", 8'(duty_level), 8'd0);
    for (int i = 0; i < 8 * PER; i++) begin
      if (duty_level === 4'(DEF)) break;
      inc_req = 1'($urandom_range(0, 1));
      dec_req = 1'($urandom_range(0, 1));
      tick();
    end
    inc_req = 1'b0; dec_req = 1'b0;
    check("ramp_end_level", 8'(duty_level), 8'd5);
    tick();
    check("ramp_end_hold", 8'(duty_level), 8'd5);

    $display("step: randomized run/inc/dec traffic");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) inc_req = ~inc_req;
      if ($urandom_range(0, 3) == 0) dec_req = ~dec_req;
      if (!motor_running) motor_running = 1'b1;
      else if ($urandom_range(0, 149) == 0) motor_running = 1'b0;
      tick();
    end
    inc_req = 1'b0; dec_req = 1'b0; motor_running = 1'b1;
    repeat (2) tick();

    $display("step: reset mid-run");
    rst = 1'b1; tick();
    check("midrst_level",   8'(duty_level), 8'd0);
    check("midrst_display", 8'(display),    8'h40);
    check("midrst_active",  8'(active),     8'd0);
    rst = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
